// File: rtl/audio_frame_scheduler.sv
// Drains the audio sample FIFO, decimates, and packs stereo samples into a ping-pong frame buffer.
// Optional `PEAK_DETECT_EN adds per-frame |L|/|R| peak tracking; otherwise peak_l/peak_r are tied to 0.
module audio_frame_scheduler #(
  parameter  int FRAME_LEN = 256,
  parameter  int DECIM     = 1,
  parameter  int DATA_W    = 32,
  localparam int ADDR_W    = $clog2(FRAME_LEN)
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              fifo_rdempty,
  input  logic [DATA_W-1:0] fifo_q,
  output logic              fifo_rdreq,
  output logic              buf_wr_en,
  output logic [ADDR_W:0]   buf_wr_addr,
  output logic [DATA_W-1:0] buf_wr_data,
  output logic              frame_ready,
  output logic              frame_bank,
  input  logic              frame_ack,
  output logic              overrun,
  input  logic              overrun_clr,
  output logic [15:0]       peak_l,
  output logic [15:0]       peak_r
);

  localparam int DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  typedef enum logic [1:0] {IDLE, READ, WAIT, WRITE} state_t;

  state_t              state_reg;
  logic                wb_reg;
  logic [ADDR_W-1:0]   idx_reg;
  logic [DCNT_W-1:0]   dcnt_reg;
  logic                last_idx;
  logic                handover;

  assign last_idx = (idx_reg == ADDR_W'(FRAME_LEN - 1));
  // Consumer is free when it holds nothing or releases its bank in this very cycle.
  assign handover = (state_reg == WRITE) && last_idx && (!frame_ready || frame_ack);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      wb_reg      <= 1'b0;
      idx_reg     <= '0;
      dcnt_reg    <= '0;
      fifo_rdreq  <= 1'b0;
      buf_wr_en   <= 1'b0;
      buf_wr_addr <= '0;
      buf_wr_data <= '0;
      frame_ready <= 1'b0;
      frame_bank  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      fifo_rdreq <= 1'b0;
      buf_wr_en  <= 1'b0;
      if (frame_ack && frame_ready)
        frame_ready <= 1'b0;
      if (overrun_clr)
        overrun <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (enable && !fifo_rdempty) begin
            state_reg  <= READ;
            fifo_rdreq <= 1'b1;
          end
        end
        READ: state_reg <= WAIT;
        WAIT: begin
          buf_wr_data <= fifo_q;
          dcnt_reg    <= (dcnt_reg == DCNT_W'(DECIM - 1)) ? '0 : dcnt_reg + DCNT_W'(1);
          if (dcnt_reg == '0) begin
            state_reg   <= WRITE;
            buf_wr_en   <= 1'b1;
            buf_wr_addr <= {wb_reg, idx_reg};
          end else begin
            state_reg <= IDLE;
          end
        end
        WRITE: begin
          state_reg <= IDLE;
          if (last_idx) begin
            idx_reg <= '0;
            if (handover) begin
              frame_ready <= 1'b1;
              frame_bank  <= wb_reg;
              wb_reg      <= ~wb_reg;
            end else begin
              // Later assignment wins over overrun_clr above.
              overrun <= 1'b1;
            end
          end else begin
            idx_reg <= idx_reg + ADDR_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef PEAK_DETECT_EN
  logic [15:0] run_l_reg, run_r_reg;
  logic [15:0] abs_l, abs_r, run_l_next, run_r_next;

  // |-32768| has no 16-bit positive form, so it clamps to the largest one.
  function automatic logic [15:0] sat_abs(input logic signed [15:0] v);
    if (v == 16'sh8000)
      return 16'h7fff;
    return v[15] ? 16'(-v) : 16'(v);
  endfunction

  always_comb begin
    abs_l      = sat_abs(buf_wr_data[DATA_W-1 -: 16]);
    abs_r      = sat_abs(buf_wr_data[15:0]);
    run_l_next = (idx_reg == '0 || abs_l > run_l_reg) ? abs_l : run_l_reg;
    run_r_next = (idx_reg == '0 || abs_r > run_r_reg) ? abs_r : run_r_reg;
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      run_l_reg <= '0;
      run_r_reg <= '0;
      peak_l    <= '0;
      peak_r    <= '0;
    end else if (state_reg == WRITE) begin
      run_l_reg <= run_l_next;
      run_r_reg <= run_r_next;
      if (handover) begin
        peak_l <= run_l_next;
        peak_r <= run_r_next;
      end
    end
  end
`else
  assign peak_l = '0;
  assign peak_r = '0;
`endif

endmodule

// File: tb/tb_audio_frame_scheduler.sv
// Self-checking bench for audio_frame_scheduler: FIFO model, write scoreboard, handshake corner cases.
module tb_audio_frame_scheduler;

  localparam int FL = 4;
  localparam int AW = 3;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct {
    logic [31:0]   word;
    logic [AW-1:0] addr;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n = 1'b0;

  // DUT0: FRAME_LEN=4, DECIM=1
  logic          en0 = 1'b0, empty0 = 1'b1, ack0 = 1'b0, oclr0 = 1'b0;
  logic [31:0]   q0 = '0;
  logic          rdreq0, wr0, ready0, bank0, ovr0;
  logic [AW-1:0] addr0;
  logic [31:0]   data0;
  logic [15:0]   pl0, pr0;

  // DUT1: FRAME_LEN=4, DECIM=3
  logic          en1 = 1'b0, empty1 = 1'b1, ack1 = 1'b0, oclr1 = 1'b0;
  logic [31:0]   q1 = '0;
  logic          rdreq1, wr1, ready1, bank1, ovr1;
  logic [AW-1:0] addr1;
  logic [31:0]   data1;
  logic [15:0]   pl1, pr1;

  audio_frame_scheduler #(.FRAME_LEN(FL), .DECIM(1), .DATA_W(32)) dut0 (
    .CLOCK_50(clk), .reset_n(reset_n), .enable(en0), .fifo_rdempty(empty0), .fifo_q(q0),
    .fifo_rdreq(rdreq0), .buf_wr_en(wr0), .buf_wr_addr(addr0), .buf_wr_data(data0),
    .frame_ready(ready0), .frame_bank(bank0), .frame_ack(ack0), .overrun(ovr0),
    .overrun_clr(oclr0), .peak_l(pl0), .peak_r(pr0)
  );

  audio_frame_scheduler #(.FRAME_LEN(FL), .DECIM(3), .DATA_W(32)) dut1 (
    .CLOCK_50(clk), .reset_n(reset_n), .enable(en1), .fifo_rdempty(empty1), .fifo_q(q1),
    .fifo_rdreq(rdreq1), .buf_wr_en(wr1), .buf_wr_addr(addr1), .buf_wr_data(data1),
    .frame_ready(ready1), .frame_bank(bank1), .frame_ack(ack1), .overrun(ovr1),
    .overrun_clr(oclr1), .peak_l(pl1), .peak_r(pr1)
  );

  logic [31:0] fifo0[$];
  logic [31:0] fifo1[$];
  wr_t         exp0[$];
  wr_t         exp1[$];
  vec_t        vec[22];

  int compared   = 0;
  int mismatched = 0;
  int rd0_cnt    = 0;
  int rd1_cnt    = 0;
  int wr1_cnt    = 0;

  function automatic logic [15:0] exp_peak(input logic [15:0] v);
`ifdef PEAK_DETECT_EN
    return v;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  // One falling edge: FIFO read model plus write-side scoreboard for both DUTs.
  task automatic tick();
    wr_t e;
    @(negedge clk);
    if (rdreq0) begin
      rd0_cnt++;
      check("fifo0_has_data_at_rdreq", 32'(fifo0.size() > 0), 1);
      if (fifo0.size() > 0) q0 = fifo0.pop_front();
    end
    empty0 = (fifo0.size() == 0);
    if (rdreq1) begin
      rd1_cnt++;
      check("fifo1_has_data_at_rdreq", 32'(fifo1.size() > 0), 1);
      if (fifo1.size() > 0) q1 = fifo1.pop_front();
    end
    empty1 = (fifo1.size() == 0);
    if (wr0) begin
      check("wr0_expected", 32'(exp0.size() > 0), 1);
      if (exp0.size() > 0) begin
        e = exp0.pop_front();
        check("wr0_addr", 32'(addr0), 32'(e.addr));
        check("wr0_data", data0, e.data);
      end
    end
    if (wr1) begin
      wr1_cnt++;
      check("wr1_expected", 32'(exp1.size() > 0), 1);
      if (exp1.size() > 0) begin
        e = exp1.pop_front();
        check("wr1_addr", 32'(addr1), 32'(e.addr));
        check("wr1_data", data1, e.data);
      end
    end
  endtask

  task automatic push0(input logic [31:0] w, input logic [AW-1:0] a);
    fifo0.push_back(w);
    exp0.push_back('{addr: a, data: w});
  endtask

  task automatic apply(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) push0(vec[i].word, vec[i].addr);
  endtask

  task automatic drain(input int which);
    int n;
    n = 0;
    while (n < 300 && ((which == 0) ? (fifo0.size() != 0 || exp0.size() != 0)
                                    : (fifo1.size() != 0 || exp1.size() != 0))) begin
      tick();
      n++;
    end
    check("drain_timeout", 32'(n >= 300), 0);
    repeat (4) tick();
  endtask

  initial begin
    int n;
    int rd_snap;
    vec[0]  = '{32'h0001_0002, 3'd0};  vec[1]  = '{32'h0002_0003, 3'd1};
    vec[2]  = '{32'h0003_0004, 3'd2};  vec[3]  = '{32'h0004_0005, 3'd3};
    vec[4]  = '{32'h0005_0006, 3'd4};  vec[5]  = '{32'h0006_0007, 3'd5};
    vec[6]  = '{32'h0007_0008, 3'd6};  vec[7]  = '{32'h0008_0009, 3'd7};
    vec[8]  = '{32'h0009_000A, 3'd4};  vec[9]  = '{32'h000A_000B, 3'd5};
    vec[10] = '{32'h000B_000C, 3'd6};  vec[11] = '{32'h000C_000D, 3'd7};
    vec[12] = '{32'h000D_000E, 3'd0};  vec[13] = '{32'h000E_000F, 3'd1};
    vec[14] = '{32'h000F_0010, 3'd2};  vec[15] = '{32'h0010_0011, 3'd3};
    vec[16] = '{32'h8000_0064, 3'd4};  vec[17] = '{32'h0005_FF38, 3'd5};
    vec[18] = '{32'h0001_0002, 3'd6};  vec[19] = '{32'h0003_0004, 3'd7};
    vec[20] = '{32'h1234_5678, 3'd0};  vec[21] = '{32'h0BAD_0001, 3'd0};

    // Reset state
    repeat (3) tick();
    check("rst_rdreq", 32'(rdreq0), 0);
    check("rst_wr_en", 32'(wr0), 0);
    check("rst_addr", 32'(addr0), 0);
    check("rst_data", data0, 0);
    check("rst_ready", 32'(ready0), 0);
    check("rst_overrun", 32'(ovr0), 0);
    reset_n = 1'b1;
    en0 = 1'b1;
    en1 = 1'b1;

    // Decimation by 3: nine reads, three writes of w0, w3, w6
    for (int k = 0; k < 9; k++) begin
      fifo1.push_back(32'hA000_0000 + 32'(k));
      if (k % 3 == 0) exp1.push_back('{addr: AW'(k / 3), data: 32'hA000_0000 + 32'(k)});
    end
    drain(1);
    check("decim_rdreq_pulses", rd1_cnt, 9);
    check("decim_wr_pulses", wr1_cnt, 3);

    // First frame into bank 0
    apply(0, 3);
    drain(0);
    check("f0_ready", 32'(ready0), 1);
    check("f0_bank", 32'(bank0), 0);
    check("f0_overrun", 32'(ovr0), 0);
    check("f0_peak_l", 32'(pl0), 32'(exp_peak(16'd4)));
    check("f0_peak_r", 32'(pr0), 32'(exp_peak(16'd5)));

    // Bank 1 fills while consumer still holds bank 0 -> dropped
    apply(4, 7);
    drain(0);
    check("drop_overrun", 32'(ovr0), 1);
    check("drop_ready", 32'(ready0), 1);
    check("drop_bank", 32'(bank0), 0);
    check("drop_peak_l", 32'(pl0), 32'(exp_peak(16'd4)));
    oclr0 = 1'b1;
    tick();
    oclr0 = 1'b0;
    tick();
    check("overrun_cleared", 32'(ovr0), 0);

    // Ack coincides with bank 1 completion
    apply(8, 11);
    n = 0;
    while (n < 200 && !(wr0 && addr0 == 3'd7)) begin
      tick();
      n++;
    end
    check("ack_align_timeout", 32'(n >= 200), 0);
    ack0 = 1'b1;
    tick();
    ack0 = 1'b0;
    drain(0);
    check("ackhand_ready", 32'(ready0), 1);
    check("ackhand_bank", 32'(bank0), 1);
    check("ackhand_overrun", 32'(ovr0), 0);
    check("ackhand_peak_l", 32'(pl0), 32'(exp_peak(16'd12)));
    check("ackhand_peak_r", 32'(pr0), 32'(exp_peak(16'd13)));
    ack0 = 1'b1;
    tick();
    ack0 = 1'b0;
    tick();
    check("ack_clears_ready", 32'(ready0), 0);
    ack0 = 1'b1;
    tick();
    ack0 = 1'b0;
    tick();
    check("idle_ack_ready", 32'(ready0), 0);
    check("idle_ack_bank", 32'(bank0), 1);

    // enable drops during WAIT: in-flight sample still written, then parked
    apply(12, 13);
    n = 0;
    while (n < 200 && !rdreq0) begin
      tick();
      n++;
    end
    check("rdreq_wait_timeout", 32'(n >= 200), 0);
    tick();
    en0 = 1'b0;
    rd_snap = rd0_cnt;
    repeat (12) tick();
    check("parked_no_rdreq", rd0_cnt - rd_snap, 0);
    check("parked_fifo_left", fifo0.size(), 1);
    check("parked_pending_wr", exp0.size(), 1);
    en0 = 1'b1;
    drain(0);

    // Finish bank 0, release it, then the peak frame in bank 1
    apply(14, 15);
    drain(0);
    check("f2_ready", 32'(ready0), 1);
    check("f2_bank", 32'(bank0), 0);
    ack0 = 1'b1;
    tick();
    ack0 = 1'b0;
    apply(16, 19);
    drain(0);
    check("peak_ready", 32'(ready0), 1);
    check("peak_bank", 32'(bank0), 1);
    check("peak_l_sat", 32'(pl0), 32'(exp_peak(16'd32767)));
    check("peak_r", 32'(pr0), 32'(exp_peak(16'd200)));

    // Reset mid-frame discards the partial frame
    apply(20, 20);
    drain(0);
    reset_n = 1'b0;
    #1;
    check("midrst_rdreq", 32'(rdreq0), 0);
    check("midrst_wr_en", 32'(wr0), 0);
    check("midrst_addr", 32'(addr0), 0);
    check("midrst_data", data0, 0);
    check("midrst_ready", 32'(ready0), 0);
    check("midrst_bank", 32'(bank0), 0);
    check("midrst_overrun", 32'(ovr0), 0);
    check("midrst_peak_l", 32'(pl0), 0);
    check("midrst_peak_r", 32'(pr0), 0);
    tick();
    tick();
    reset_n = 1'b1;
    apply(21, 21);
    drain(0);
    check("postrst_ready", 32'(ready0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
